// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants for the joypad debouncer.
// Holds the button bit mapping, the button count and the 2-bit per-button
// debounce state encoding used by debounce_cell.
package joypad_pkg;

    // Number of physical buttons conditioned by the block.
    localparam int NUM_BUTTONS = 6;

    // Bit positions inside iRawButtons / oButtonRegister / oPressMask.
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_UP    = 2;
    localparam int JOY_DOWN  = 3;
    localparam int JOY_A     = 4;
    localparam int JOY_B     = 5;

    // Per-button debounce state encoding.
    localparam logic [1:0] REL       = 2'd0;  // released and stable
    localparam logic [1:0] CHK_PRESS = 2'd1;  // candidate press being qualified
    localparam logic [1:0] HELD      = 2'd2;  // pressed and stable
    localparam logic [1:0] CHK_REL   = 2'd3;  // candidate release being qualified

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: conditions one raw push-button.
// Contains a 2-flop synchroniser, a four-state debounce FSM with a
// saturating stability counter, and the registered level / press pulse.
// Optional feature macro: JOYPAD_AUTOREPEAT_EN adds a per-button repeat
// counter that re-pulses the press output while the button stays held.
module debounce_cell
    import joypad_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 32'h8000,
    parameter int REPEAT_PERIOD   = 32'h2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_next
);

    // The entry edge into a CHK state is the first stable observation, so
    // the counter holds "stable cycles seen beyond the first". A change is
    // accepted once the incremented count reaches DEBOUNCE_CYCLES-1, which
    // gives exactly DEBOUNCE_CYCLES consecutive stable synced samples.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [1:0]       sync_reg;
    logic             synced;
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_reg;
    logic             level_next;
    logic             press_reg;
    logic             accept_press;

    assign synced = sync_reg[1];

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], raw};
        end
    end

    // Saturating increment so a long-stable input can never wrap the count.
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    // Debounce FSM: qualify each candidate level change for the full window.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        accept_press = 1'b0;
        case (state_reg)
            REL: begin
                if (synced) begin
                    cnt_next = '0;
                    if (SINGLE) begin
                        state_next   = HELD;
                        level_next   = 1'b1;
                        accept_press = 1'b1;
                    end else begin
                        state_next = CHK_PRESS;
                    end
                end
            end
            CHK_PRESS: begin
                if (!synced) begin
                    // Glitch shorter than the window: drop it.
                    state_next = REL;
                    cnt_next   = '0;
                end else if (cnt_inc == LAST_CNT) begin
                    state_next   = HELD;
                    cnt_next     = '0;
                    level_next   = 1'b1;
                    accept_press = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            HELD: begin
                if (!synced) begin
                    cnt_next = '0;
                    if (SINGLE) begin
                        state_next = REL;
                        level_next = 1'b0;
                    end else begin
                        state_next = CHK_REL;
                    end
                end
            end
            CHK_REL: begin
                if (synced) begin
                    // Release bounce: button still considered held.
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_inc == LAST_CNT) begin
                    // Release accepted silently; no press pulse.
                    state_next = REL;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = REL;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

`ifdef JOYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rep_cnt_reg;
    logic [CNT_W-1:0] rep_cnt_next;
    logic [CNT_W-1:0] rep_inc;
    logic             rep_armed_reg;
    logic             rep_armed_next;
    logic             rep_fire;
    logic             stay_held;

    // Only a cycle that both starts and ends in HELD advances the repeat
    // timer; any other cycle (including the acceptance edge) restarts it.
    assign stay_held = (state_reg == HELD) && (state_next == HELD);
    assign rep_inc   = (rep_cnt_reg == CNT_MAX) ? rep_cnt_reg : rep_cnt_reg + 1'b1;

    // Repeat timer: first interval is REPEAT_DELAY, then REPEAT_PERIOD.
    always_comb begin
        rep_cnt_next   = '0;
        rep_armed_next = 1'b0;
        rep_fire       = 1'b0;
        if (stay_held) begin
            rep_armed_next = rep_armed_reg;
            if (rep_inc == (rep_armed_reg ? REP_PERIOD : REP_DELAY)) begin
                rep_fire       = 1'b1;
                rep_cnt_next   = '0;
                rep_armed_next = 1'b1;
            end else begin
                rep_cnt_next = rep_inc;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_reg   <= '0;
            rep_armed_reg <= 1'b0;
        end else begin
            rep_cnt_reg   <= rep_cnt_next;
            rep_armed_reg <= rep_armed_next;
        end
    end

    assign press_next = accept_press | rep_fire;
`else
    assign press_next = accept_press;
`endif

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= REL;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            press_reg <= press_next;
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/joypad_debouncer.sv
// joypad_debouncer: six independent debounce cells feeding the pGB
// iButtonRegister, plus a registered joypad interrupt request that is
// high in the same cycle as any oPressMask bit.
// Optional feature macro: JOYPAD_AUTOREPEAT_EN (auto-repeat press pulses).
module joypad_debouncer
    import joypad_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 32'h8000,
    parameter int REPEAT_PERIOD   = 32'h2000
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic [NUM_BUTTONS-1:0] iRawButtons,
    output logic [NUM_BUTTONS-1:0] oButtonRegister,
    output logic [NUM_BUTTONS-1:0] oPressMask,
    output logic                   oPressEvent
);

    logic [NUM_BUTTONS-1:0] press_next_bus;
    logic                   event_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_cell
            debounce_cell #(
                .CNT_W          (CNT_W),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_cell (
                .clk       (iClock),
                .rst_n     (iReset),
                .raw       (iRawButtons[gi]),
                .level     (oButtonRegister[gi]),
                .press     (oPressMask[gi]),
                .press_next(press_next_bus[gi])
            );
        end
    endgenerate

    // Interrupt request: OR of the cells' next-cycle pulses, registered so
    // it lines up exactly with the registered oPressMask bits.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            event_reg <= 1'b0;
        end else begin
            event_reg <= |press_next_bus;
        end
    end

    assign oPressEvent = event_reg;

endmodule

// File: tb/tb_joypad_debouncer.sv
// tb_joypad_debouncer: self-checking bench for joypad_debouncer.
// Expected press pulses are queued with their cycle number when stimulus is
// driven; a negedge monitor pops and compares them against oPressMask and
// oPressEvent. Level checks are done inline by each scenario task.
module tb_joypad_debouncer;
    import joypad_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] raw = 6'h00;
    logic [5:0] btn;
    logic [5:0] mask;
    logic       evt;

    joypad_debouncer #(
        .CNT_W          (16),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .iClock         (clk),
        .iReset         (rst_n),
        .iRawButtons    (raw),
        .oButtonRegister(btn),
        .oPressMask     (mask),
        .oPressEvent    (evt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
    } ev_t;
    ev_t sb[$];

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    // Queue an expected press pulse at the given cycle (merged if same cycle).
    task automatic expect_press(input int c, input logic [5:0] m);
        ev_t e;
        if (sb.size() > 0 && sb[sb.size()-1].cyc == c) begin
            e = sb[sb.size()-1];
            e.mask = e.mask | m;
            sb[sb.size()-1] = e;
        end else begin
            e.cyc  = c;
            e.mask = m;
            sb.push_back(e);
        end
    endtask

    // Move to just after the next active edge; returns that edge number.
    task automatic next_edge(output int e);
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    // Advance to the negedge following edge c.
    task automatic to_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Scoreboard monitor: compare pulses every cycle against queued events.
    always @(negedge clk) begin
        logic [5:0] exp_mask;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL press_missed cycle=%0d expected_mask=%02h", sb[0].cyc, sb[0].mask);
                void'(sb.pop_front());
            end
            exp_mask = 6'h00;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_mask = sb[0].mask;
                void'(sb.pop_front());
            end
            if (mask !== 6'h00 || exp_mask !== 6'h00)
                $display("press cycle=%0d mask=%02h expected=%02h event=%0b", cyc, mask, exp_mask, evt);
            checks++;
            if (mask !== exp_mask) begin
                failures++;
                $display("FAIL press_mask cycle=%0d got=%02h expected=%02h", cyc, mask, exp_mask);
            end
            checks++;
            if (evt !== (exp_mask != 6'h00)) begin
                failures++;
                $display("FAIL press_event cycle=%0d got=%0b expected=%0b", cyc, evt, (exp_mask != 6'h00));
            end
        end
    end

    task automatic test_reset();
        int e;
        raw   = 6'h3F;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL reset_btn got=%02h expected=00", btn); end
        checks++;
        if (mask !== 6'h00) begin failures++; $display("FAIL reset_mask got=%02h expected=00", mask); end
        checks++;
        if (evt !== 1'b0) begin failures++; $display("FAIL reset_event got=%0b expected=0", evt); end
        mon_en = 1'b1;
        // Buttons already held at reset release are a fresh press.
        next_edge(e);
        rst_n = 1'b1;
        expect_press(e + DEB + 2, 6'h3F);
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL reset_early got=%02h expected=00", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h3F) begin failures++; $display("FAIL reset_held got=%02h expected=3f", btn); end
        next_edge(e);
        raw = 6'h00;
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h3F) begin failures++; $display("FAIL release_early got=%02h expected=3f", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL release_all got=%02h expected=00", btn); end
        // Reset in the middle of a debounce must discard the partial count.
        next_edge(e);
        raw = 6'h01;
        to_neg(e + 4);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        next_edge(e);
        rst_n = 1'b1;
        expect_press(e + DEB + 2, 6'h01);
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL midreset_early got=%02h expected=00", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h01) begin failures++; $display("FAIL midreset_accept got=%02h expected=01", btn); end
        next_edge(e);
        raw = 6'h00;
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL midreset_release got=%02h expected=00", btn); end
    endtask

    task automatic test_clean_press();
        int e;
        next_edge(e);
        raw = 6'h10;
        expect_press(e + DEB + 2, 6'h10);
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL clean_early got=%02h expected=00", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h10) begin failures++; $display("FAIL clean_accept got=%02h expected=10", btn); end
        next_edge(e);
        raw = 6'h00;
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h10) begin failures++; $display("FAIL clean_rel_early got=%02h expected=10", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL clean_release got=%02h expected=00", btn); end
    endtask

    task automatic test_glitch();
        int e;
        // Three-cycle pulse: one short of the window, never accepted.
        next_edge(e);
        raw = 6'h01;
        repeat (DEB - 1) @(posedge clk);
        #1 raw = 6'h00;
        to_neg(e + 12);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL glitch_reject got=%02h expected=00", btn); end
        // Exactly DEB cycles: accepted.
        next_edge(e);
        raw = 6'h01;
        expect_press(e + DEB + 2, 6'h01);
        repeat (DEB) @(posedge clk);
        #1 raw = 6'h00;
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h01) begin failures++; $display("FAIL glitch_exact got=%02h expected=01", btn); end
        to_neg(e + 2 * DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL glitch_exact_rel got=%02h expected=00", btn); end
    endtask

    task automatic test_bounce();
        int e;
        next_edge(e); raw = 6'h04;
        next_edge(e); raw = 6'h00;
        next_edge(e); raw = 6'h04;
        next_edge(e); raw = 6'h00;
        next_edge(e); raw = 6'h04;
        expect_press(e + DEB + 2, 6'h04);
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL bounce_early got=%02h expected=00", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h04) begin failures++; $display("FAIL bounce_accept got=%02h expected=04", btn); end
        next_edge(e); raw = 6'h00;
        next_edge(e); raw = 6'h04;
        next_edge(e); raw = 6'h00;
        to_neg(e + DEB + 1);
        checks++;
        if (btn !== 6'h04) begin failures++; $display("FAIL bounce_rel_early got=%02h expected=04", btn); end
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL bounce_release got=%02h expected=00", btn); end
    endtask

    task automatic test_simultaneous();
        int e;
        int e2;
        next_edge(e);
        raw = 6'h22;
        expect_press(e + DEB + 2, 6'h22);
        next_edge(e2);
        raw = 6'h23;
        expect_press(e2 + DEB + 2, 6'h01);
        to_neg(e2 + DEB + 2);
        checks++;
        if (btn !== 6'h23) begin failures++; $display("FAIL simul_level got=%02h expected=23", btn); end
        next_edge(e);
        raw = 6'h00;
        to_neg(e + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL simul_release got=%02h expected=00", btn); end
    endtask

    task automatic test_autorepeat();
        int e;
        int a;
        next_edge(e);
        raw = 6'h08;
        a = e + DEB + 2;
        expect_press(a, 6'h08);
`ifdef JOYPAD_AUTOREPEAT_EN
        expect_press(a + RD, 6'h08);
        expect_press(a + RD + RP, 6'h08);
        expect_press(a + RD + 2 * RP, 6'h08);
        expect_press(a + RD + 3 * RP, 6'h08);
`endif
        to_neg(a + 26);
        checks++;
        if (btn !== 6'h08) begin failures++; $display("FAIL repeat_level got=%02h expected=08", btn); end
        // Released so the cell leaves HELD before offset 30.
        raw = 6'h00;
        to_neg(a + 26 + DEB + 1);
        checks++;
        if (btn !== 6'h08) begin failures++; $display("FAIL repeat_rel_early got=%02h expected=08", btn); end
        to_neg(a + 26 + DEB + 2);
        checks++;
        if (btn !== 6'h00) begin failures++; $display("FAIL repeat_release got=%02h expected=00", btn); end
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_autorepeat();
        to_neg(cyc + 10);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
